// File: rtl/simon_pkg.sv
// Shared types and defaults for the Simon playback blocks.
package simon_pkg;

   localparam int unsigned NUM_COLOURS_D = 4;
   localparam int unsigned MAX_ROUNDS_D  = 33;

   typedef logic [$clog2(NUM_COLOURS_D)-1:0] colour_t;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      ON,
      GAP,
      DONE
   } flash_state_t;

endpackage

// File: rtl/seq_flasher_colour_decode.sv
// colour_decode: colour code to one-hot lamp vector; codes >= NUM_COLOURS give all-zero.
module colour_decode #(
   parameter int unsigned NUM_COLOURS = 4,
   parameter int unsigned COL_W       = $clog2(NUM_COLOURS)
) (
   input  logic [COL_W-1:0]       code,
   output logic [NUM_COLOURS-1:0] onehot
);

   // One lamp per legal code; no match leaves the vector dark.
   always_comb begin
      onehot = '0;
      for (int unsigned i = 0; i < NUM_COLOURS; i++) begin
         if (code == COL_W'(i)) onehot[i] = 1'b1;
      end
   end

endmodule

// File: rtl/seq_flasher.sv
// seq_flasher: plays back the stored Simon sequence on the lamps with
// cycle-timed on/off windows and pulses done on completion.
// Optional build macro SEQ_FLASH_SPEEDUP_EN shortens the on-time as rounds grow.
module seq_flasher
   import simon_pkg::*;
#(
   parameter int unsigned NUM_COLOURS   = NUM_COLOURS_D,
   parameter int unsigned COL_W         = $clog2(NUM_COLOURS),
   parameter int unsigned MAX_ROUNDS    = MAX_ROUNDS_D,
   parameter int unsigned IDX_W         = $clog2(MAX_ROUNDS + 1),
   parameter int unsigned ON_CYCLES     = 4,
   parameter int unsigned OFF_CYCLES    = 2,
   parameter int          SPEED_STEP    = 0,
   parameter int          MIN_ON_CYCLES = 1
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic                        start,
   input  logic                        abort,
   input  logic [IDX_W-1:0]            round_len,
   input  logic [MAX_ROUNDS*COL_W-1:0] segment,
   input  logic [NUM_COLOURS-1:0]      player_input,
   output logic [NUM_COLOURS-1:0]      disp_o,
   output logic                        busy,
   output logic                        done,
   output logic [IDX_W-1:0]            play_idx
);

   if (NUM_COLOURS < 2 || ON_CYCLES < 1 || OFF_CYCLES < 1 || MIN_ON_CYCLES < 1 ||
       SPEED_STEP < 0 || MAX_ROUNDS < 1) begin : g_param_check
      $error("seq_flasher: illegal parameter set");
   end

   flash_state_t     state_q, state_d;
   logic [IDX_W-1:0] idx_d;
   logic [31:0]      timer_q, timer_d;
   logic [COL_W-1:0] colour_q, colour_d;
   logic [IDX_W-1:0] len_q, len_d;
   logic [IDX_W:0]   nxt_idx;
   logic [IDX_W:0]   rd_idx;
   logic [COL_W-1:0] rd_code;
   logic [NUM_COLOURS-1:0] lamp;
   logic [31:0]      on_len_load;
   logic [31:0]      on_len_run;

`ifdef SEQ_FLASH_SPEEDUP_EN
   localparam logic [63:0] HEADROOM = (ON_CYCLES > MIN_ON_CYCLES) ?
                                      64'(ON_CYCLES - MIN_ON_CYCLES) : 64'd0;
   logic [63:0] reduction;
   logic [31:0] on_len_q;

   // Saturating on-time for this round; reduction is wide so it can never wrap.
   always_comb begin
      reduction = 64'(len_q) * 64'(SPEED_STEP);
      if (reduction >= HEADROOM) on_len_load = 32'(MIN_ON_CYCLES);
      else                       on_len_load = 32'(ON_CYCLES) - reduction[31:0];
   end

   // Latch the on-time once in LOAD so it stays fixed for the whole playback.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)              on_len_q <= 32'(ON_CYCLES);
      else if (state_q == LOAD)  on_len_q <= on_len_load;
   end

   assign on_len_run = on_len_q;
`else
   assign on_len_load = 32'(ON_CYCLES);
   assign on_len_run  = 32'(ON_CYCLES);
`endif

   assign nxt_idx = {1'b0, play_idx} + 1'b1;
   assign rd_idx  = (state_q == LOAD) ? '0 : nxt_idx;

   // Select the code of the element about to be shown.
   always_comb begin
      rd_code = '0;
      for (int unsigned k = 0; k < MAX_ROUNDS; k++) begin
         if (rd_idx == (IDX_W+1)'(k)) rd_code = segment[k*COL_W +: COL_W];
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         play_idx <= '0;
         timer_q  <= '0;
         colour_q <= '0;
         len_q    <= '0;
      end else begin
         state_q  <= state_d;
         play_idx <= idx_d;
         timer_q  <= timer_d;
         colour_q <= colour_d;
         len_q    <= len_d;
      end
   end

   // Next-state and datapath updates; abort overrides everything outside IDLE.
   always_comb begin
      state_d  = state_q;
      idx_d    = play_idx;
      timer_d  = timer_q;
      colour_d = colour_q;
      len_d    = len_q;
      if (abort && state_q != IDLE) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  state_d = LOAD;
                  len_d   = (round_len > IDX_W'(MAX_ROUNDS)) ? IDX_W'(MAX_ROUNDS) : round_len;
               end
            end
            LOAD: begin
               if (len_q == '0) begin
                  state_d = DONE;
               end else begin
                  state_d  = ON;
                  idx_d    = '0;
                  colour_d = rd_code;
                  timer_d  = on_len_load - 32'd1;
               end
            end
            ON: begin
               if (timer_q == '0) begin
                  state_d = GAP;
                  timer_d = 32'(OFF_CYCLES - 1);
               end else begin
                  timer_d = timer_q - 32'd1;
               end
            end
            GAP: begin
               if (timer_q != '0) begin
                  timer_d = timer_q - 32'd1;
               end else if (nxt_idx < {1'b0, len_q}) begin
                  state_d  = ON;
                  idx_d    = nxt_idx[IDX_W-1:0];
                  colour_d = rd_code;
                  timer_d  = on_len_run - 32'd1;
               end else begin
                  state_d = DONE;
               end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   colour_decode #(
      .NUM_COLOURS (NUM_COLOURS),
      .COL_W       (COL_W)
   ) u_decode (
      .code   (colour_q),
      .onehot (lamp)
   );

   // Lamp drive: player buttons always pass through; reset blanks everything.
   always_comb begin
      disp_o = '0;
      if (reset_n) disp_o = player_input | ((state_q == ON) ? lamp : '0);
   end

   assign busy = (state_q != IDLE);
   assign done = (state_q == DONE);

endmodule

// File: tb/tb_seq_flasher.sv
// Directed bench for seq_flasher: timeline table plus hand-written corner sequences.
module tb_seq_flasher;

   localparam int IDX_W = 6;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start;
   logic        abort;
   logic [5:0]  round_len;
   logic [65:0] segment;
   logic [3:0]  pin;
   logic [3:0]  disp;
   logic        busy, done;
   logic [5:0]  play_idx;
   logic [2:0]  pin3;
   logic [2:0]  disp3;
   logic        busy3, done3;
   logic [5:0]  idx3;

   int pass_cnt = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   seq_flasher #(.SPEED_STEP(1), .MIN_ON_CYCLES(1)) u_dut (
      .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
      .round_len(round_len), .segment(segment), .player_input(pin),
      .disp_o(disp), .busy(busy), .done(done), .play_idx(play_idx)
   );

   seq_flasher #(.NUM_COLOURS(3), .SPEED_STEP(1), .MIN_ON_CYCLES(1)) u_dut3 (
      .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
      .round_len(round_len), .segment(segment), .player_input(pin3),
      .disp_o(disp3), .busy(busy3), .done(done3), .play_idx(idx3)
   );

   typedef struct {
      logic [3:0] pin;
      logic [3:0] disp;
      logic       busy;
      logic       done;
      int         idx;
   } vec_t;

   vec_t tv[22];

   task automatic check(input string name, input int act, input int exp);
      total_cnt++;
      if (act == exp) pass_cnt++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   function automatic int exp_on(input int len);
      int l;
      l = (len > 33) ? 33 : len;
`ifdef SEQ_FLASH_SPEEDUP_EN
      return (4 - l < 1) ? 1 : 4 - l;
`else
      return (l >= 0) ? 4 : 0;
`endif
   endfunction

   function automatic int exp_done(input int len);
      int l;
      l = (len > 33) ? 33 : len;
      return 2 + l * (exp_on(len) + 2);
   endfunction

   task automatic set_seg(input int k, input logic [1:0] code);
      segment[k*2 +: 2] = code;
   endtask

   // Runs one playback with player_input idle; optionally re-pulses start mid-run.
   task automatic play(input int len, input int restart_cyc,
                       output int done_cyc, output int lit, output int flashes,
                       output int lit3, output int done_cnt);
      logic prev;
      @(posedge clk); #1;
      pin = '0; round_len = 6'(len); start = 1'b1;
      done_cyc = -1; lit = 0; flashes = 0; lit3 = 0; done_cnt = 0; prev = 1'b0;
      for (int c = 1; c <= 400; c++) begin
         @(posedge clk); #1;
         start = (c == restart_cyc);
         if (c == restart_cyc) round_len = 6'd5;
         #1;
         if (disp != 4'd0) lit++;
         if (disp != 4'd0 && !prev) flashes++;
         prev = (disp != 4'd0);
         if (disp3 != 3'd0) lit3++;
         if (done) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = c;
         end
         if (!busy && c > 1) break;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running, expected to finish");
      $fatal(1);
   end

   initial begin
      int dc, lit, fl, lit3, dn;
      reset_n = 1'b0; start = 1'b0; abort = 1'b0; round_len = '0;
      segment = '0; pin = 4'b1111; pin3 = '0;

      // Reset state
      #12;
      check("reset.disp", int'(disp), 0);
      check("reset.busy", int'(busy), 0);
      check("reset.done", int'(done), 0);
      check("reset.idx", int'(play_idx), 0);
      @(posedge clk); #1; reset_n = 1'b1; pin = '0;

      // Three-element timeline, codes 2,0,3, with overlay in ON and GAP
      for (int c = 0; c < 22; c++) begin
         tv[c].pin  = 4'b0000;
         tv[c].disp = 4'b0000;
         tv[c].busy = (c >= 1 && c <= 20);
         tv[c].done = (c == 20);
         tv[c].idx  = (c < 8) ? 0 : (c < 14) ? 1 : 2;
         if (c >= 2 && c <= 5)   tv[c].disp = 4'b0100;
         if (c >= 8 && c <= 11)  tv[c].disp = 4'b0001;
         if (c >= 14 && c <= 17) tv[c].disp = 4'b1000;
      end
      tv[3].pin  = 4'b0010; tv[3].disp  = 4'b0110;
      tv[6].pin  = 4'b0010; tv[6].disp  = 4'b0010;
      tv[21].pin = 4'b1001; tv[21].disp = 4'b1001;

      set_seg(0, 2'd2); set_seg(1, 2'd0); set_seg(2, 2'd3);
`ifndef SEQ_FLASH_SPEEDUP_EN
      @(posedge clk); #1;
      round_len = 6'd3; start = 1'b1; pin = tv[0].pin; #1;
      check("tv0.busy", int'(busy), int'(tv[0].busy));
      check("tv0.disp", int'(disp), int'(tv[0].disp));
      for (int c = 1; c < 22; c++) begin
         @(posedge clk); #1;
         start = 1'b0; pin = tv[c].pin; #1;
         check($sformatf("tv%0d.disp", c), int'(disp), int'(tv[c].disp));
         check($sformatf("tv%0d.busy", c), int'(busy), int'(tv[c].busy));
         check($sformatf("tv%0d.done", c), int'(done), int'(tv[c].done));
         check($sformatf("tv%0d.idx", c), int'(play_idx), tv[c].idx);
      end
`endif
      pin = '0;

      // Zero-length round: DONE straight after LOAD, nothing lit
      play(0, 0, dc, lit, fl, lit3, dn);
      check("len0.done_cyc", dc, 2);
      check("len0.lit", lit, 0);

      // Start while busy is ignored
      play(3, 3, dc, lit, fl, lit3, dn);
      check("restart.done_cyc", dc, exp_done(3));
      check("restart.flashes", fl, 3);
      check("restart.done_cnt", dn, 1);

      // Out-of-range code on the 3-colour instance gives a dark ON window
      set_seg(0, 2'd3); set_seg(1, 2'd1);
      play(2, 0, dc, lit, fl, lit3, dn);
      check("nc3.lit4", lit, 2 * exp_on(2));
      check("nc3.lit3", lit3, exp_on(2));
      check("nc3.done_cyc", dc, exp_done(2));

      // round_len above MAX_ROUNDS is clamped to 33 flashes
      for (int k = 0; k < 33; k++) set_seg(k, 2'd1);
      play(40, 0, dc, lit, fl, lit3, dn);
      check("len40.flashes", fl, 33);
      check("len40.lit", lit, 33 * exp_on(40));
      check("len40.done_cyc", dc, exp_done(40));

      // On-time for a longer round (shortens only with the speed-up build)
      play(5, 0, dc, lit, fl, lit3, dn);
      check("len5.lit", lit, 5 * exp_on(5));

      // Abort mid-playback: immediate IDLE, no done pulse
      set_seg(0, 2'd2);
      @(posedge clk); #1;
      round_len = 6'd3; start = 1'b1;
      dn = 0;
      for (int c = 1; c <= 30; c++) begin
         @(posedge clk); #1;
         start = 1'b0;
         abort = (c == 4);
         if (c == 4) pin = 4'b0001;
         #1;
         if (done) dn++;
         if (c == 5) begin
            check("abort.busy", int'(busy), 0);
            check("abort.disp", int'(disp), 1);
         end
      end
      check("abort.no_done", dn, 0);
      pin = '0; abort = 1'b0;

      // Reset dropped mid-ON
      @(posedge clk); #1;
      round_len = 6'd3; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      pin = 4'b1111; reset_n = 1'b0; #1;
      check("midrst.disp", int'(disp), 0);
      check("midrst.busy", int'(busy), 0);
      @(posedge clk); #1; reset_n = 1'b1;
      @(posedge clk); #1;
      check("midrst.idle_busy", int'(busy), 0);
      check("midrst.idle_disp", int'(disp), 15);
      check("midrst.idx", int'(play_idx), 0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
